// File: rtl/hazard_unit_gen2.sv
// Hazard controller for the 5-stage F/D/E/M/W pipeline: operand forwarding
// into E, multi-cycle load-use interlock, branch flush and data-memory wait
// handling with a sticky timeout flag and a stall-cycle performance counter.
module hazard_unit_gen2 #(
   parameter int RA_W     = 4,
   parameter int PC_REG   = 15,
   parameter int LOAD_LAT = 1,
   parameter int TIMEOUT  = 255,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [RA_W-1:0]  RA1D,
   input  logic [RA_W-1:0]  RA2D,
   input  logic [RA_W-1:0]  RA1E,
   input  logic [RA_W-1:0]  RA2E,
   input  logic [RA_W-1:0]  WA3E,
   input  logic [RA_W-1:0]  WA3M,
   input  logic [RA_W-1:0]  WA3W,
   input  logic             RegWriteE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemtoRegE,
   input  logic             BranchTakenE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             MemTimeout,
   output logic [CNT_W-1:0] StallCount
);

   localparam int            TC_W   = $clog2(TIMEOUT + 1);
   localparam logic [2:0]    LAT_M1 = 3'(LOAD_LAT - 1);
   localparam logic [TC_W-1:0] TC_MAX = TC_W'(TIMEOUT);
   localparam logic [RA_W-1:0] PC_RA = RA_W'(PC_REG);

   typedef enum logic [1:0] {IDLE, LDSTALL, MEMWAIT} state_t;

   state_t            state_q, state_d;
   logic [2:0]        ldcnt_q, ldcnt_d;
   logic [TC_W-1:0]   tcnt_q, tcnt_d;
   logic              timeout_q, timeout_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic ldhit, memwait, branch, load_stall;

   assign ldhit   = MemtoRegE && RegWriteE && (RA1D == WA3E || RA2D == WA3E);
   assign memwait = MemReqM && !MemReadyM;
   assign branch  = BranchTakenE && !memwait;

   // Forward select for both E-stage operands; M result wins over W result.
   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (RegWriteM && WA3M == RA1E && RA1E != PC_RA)      ForwardAE = 2'b10;
      else if (RegWriteW && WA3W == RA1E && RA1E != PC_RA) ForwardAE = 2'b01;
      if (RegWriteM && WA3M == RA2E && RA2E != PC_RA)      ForwardBE = 2'b10;
      else if (RegWriteW && WA3W == RA2E && RA2E != PC_RA) ForwardBE = 2'b01;
   end

   // Interlock sequencer: next state, load-stall counter, wait timeout.
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      ldcnt_d    = ldcnt_q;
      tcnt_d     = tcnt_q;
      timeout_d  = timeout_q;
      load_stall = 1'b0;
      case (state_q)
         IDLE: begin
            if (memwait) begin
               state_d = MEMWAIT;
               tcnt_d  = TC_W'(1);
            end else if (ldhit && !BranchTakenE) begin
               load_stall = 1'b1;
               if (LOAD_LAT > 1) begin
                  state_d = LDSTALL;
                  ldcnt_d = LAT_M1;
               end
            end
         end
         LDSTALL: begin
            if (memwait) begin
               // Remaining ldcnt is kept and resumed once memory completes.
               state_d = MEMWAIT;
               tcnt_d  = TC_W'(1);
            end else if (BranchTakenE) begin
               state_d = IDLE;
               ldcnt_d = 3'd0;
            end else begin
               load_stall = 1'b1;
               if (ldcnt_q <= 3'd1) begin
                  state_d = IDLE;
                  ldcnt_d = 3'd0;
               end else begin
                  ldcnt_d = ldcnt_q - 3'd1;
               end
            end
         end
         MEMWAIT: begin
            if (memwait) begin
               if (tcnt_q != TC_MAX) tcnt_d = tcnt_q + TC_W'(1);
            end else begin
               tcnt_d = '0;
               if (ldcnt_q != 3'd0 && !BranchTakenE) begin
                  state_d = LDSTALL;
               end else begin
                  // Nothing left to resume: act as IDLE for a fresh hazard.
                  state_d = IDLE;
                  ldcnt_d = 3'd0;
                  if (ldhit && !BranchTakenE) begin
                     load_stall = 1'b1;
                     if (LOAD_LAT > 1) begin
                        state_d = LDSTALL;
                        ldcnt_d = LAT_M1;
                     end
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
            ldcnt_d = 3'd0;
            tcnt_d  = '0;
         end
      endcase
      if (tcnt_d == TC_MAX) timeout_d = 1'b1;
   end

   // Stall/flush map: memory wait overrides branch, branch overrides load stall.
   always_comb begin
      StallF = memwait || load_stall;
      StallD = memwait || load_stall;
      StallE = memwait;
      StallM = memwait;
      FlushW = memwait;
      FlushD = branch;
      FlushE = branch || load_stall;
   end

   // Saturating count of cycles spent with the fetch stage held.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (StallF && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   // State registers; async reset drops any in-flight stall sequence.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ldcnt_q     <= 3'd0;
         tcnt_q      <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the
         // pre-edge values regardless of statement order.
         state_q     <= state_d;
         ldcnt_q     <= ldcnt_d;
         tcnt_q      <= tcnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign MemTimeout = timeout_q;
   assign StallCount = stall_cnt_q;

endmodule

// File: doc/hazard_unit_gen2.md
Name: hazard_unit_gen2

Overview:
Second-generation hazard controller for the 5-stage pipelined processor (F/D/E/M/W). It keeps operand forwarding into E and load-use interlocking. It adds parametrised register-address width, a multi-cycle load-use stall sequencer, branch flush, and a data-memory wait handshake with timeout detection. Purely a control block: it drives the stall, flush and forward-select signals consumed by the pipeline registers and E-stage muxes.

Parameters:
RA_W, 4, register address width
PC_REG, 15, register index never forwarded (PC reads bypass forwarding)
LOAD_LAT, 1, stall cycles inserted per load-use hazard (1..7)
TIMEOUT, 255, max consecutive memory-wait cycles before MemTimeout
CNT_W, 16, width of stall-cycle performance counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
RA1D, RA2D  in  RA_W  source regs in D
RA1E, RA2E  in  RA_W  source regs in E
WA3E, WA3M, WA3W  in  RA_W  dest regs in E/M/W
RegWriteE, RegWriteM, RegWriteW  in  1  dest write enables
MemtoRegE  in  1  E-stage instruction is a load
BranchTakenE  in  1  branch resolved taken in E
MemReqM  in  1  load/store active in M
MemReadyM  in  1  data memory completes this cycle
ForwardAE, ForwardBE  out  2  00 regfile, 01 W result, 10 M ALU result
StallF, StallD, StallE, StallM  out  1  hold stage register
FlushD, FlushE, FlushW  out  1  bubble into stage register
MemTimeout  out  1  sticky error flag
StallCount  out  CNT_W  cycles with StallF=1 since reset

Behaviour:
- Forwarding (combinational, per operand X∈{1,2}):
  - 10 if RegWriteM && WA3M==RAXE && RAXE!=PC_REG.
  - else 01 if RegWriteW && WA3W==RAXE && RAXE!=PC_REG.
  - else 00. M has priority over W.
- ldhit = MemtoRegE && RegWriteE && (RA1D==WA3E || RA2D==WA3E).
- memwait = MemReqM && !MemReadyM.
- FSM states IDLE, LDSTALL, MEMWAIT; 3-bit down-counter ldcnt; timeout counter tcnt (ceil(log2(TIMEOUT+1)) bits).
- IDLE:
  - memwait → MEMWAIT.
  - else ldhit && !BranchTakenE → outputs load stall this cycle. If LOAD_LAT>1, go to LDSTALL with ldcnt=LOAD_LAT-1.
- LDSTALL:
  - Load stall output every cycle; ldcnt decrements.
  - Leave to IDLE when ldcnt reaches 1 at the edge, so exactly LOAD_LAT total stall cycles.
  - memwait takes priority → MEMWAIT; the remaining ldcnt is retained and resumed after MEMWAIT.
- MEMWAIT:
  - Each cycle: tcnt++.
  - On !memwait → return to LDSTALL if ldcnt>0, else IDLE; tcnt cleared.
  - When tcnt reaches TIMEOUT, MemTimeout=1. It is sticky until reset; the FSM keeps waiting.
- Output map:
  - Load stall: StallF=StallD=1, FlushE=1, all others 0.
  - Memory wait (combinational on memwait, in any state): StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. Overrides load stall and branch.
  - Branch (BranchTakenE && !memwait): FlushD=FlushE=1, StallF=StallD=0. Overrides a same-cycle ldhit. A branch arriving in LDSTALL aborts it to IDLE with ldcnt=0.
  - Otherwise all stall/flush outputs 0.
- StallCount increments each cycle StallF=1 and saturates at all-ones.
- Reset (async): state IDLE, ldcnt=0, tcnt=0, MemTimeout=0, StallCount=0. Forward/stall/flush outputs then follow inputs combinationally; all are 0 when inputs are idle.
- Reset asserted mid-LDSTALL or mid-MEMWAIT returns to IDLE immediately; no residual stall after deassertion.

Test Plan:
- RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 → ForwardAE=10. Repeat with RA1E=15 → ForwardAE=00.
- LOAD_LAT=1, MemtoRegE=1, RegWriteE=1, WA3E=5, RA2D=5 → one cycle StallF=StallD=FlushE=1, then 0. StallCount=1.
- LOAD_LAT=3, same hazard → exactly 3 consecutive stall cycles, then release. StallCount=3.
- ldhit and BranchTakenE together → FlushD=FlushE=1, StallF=0. LDSTALL not entered.
- MemReqM=1, MemReadyM=0 for 4 cycles during the 2nd LDSTALL cycle → 4 cycles of StallF/D/E/M=1, FlushW=1. Then 1 remaining load-stall cycle.
- TIMEOUT=4, MemReadyM held 0 for 6 cycles → MemTimeout rises after the 4th wait cycle and stays 1 after MemReadyM=1. Clears only on reset pulse mid-wait; FSM IDLE next cycle.
